// File: rtl/router_1xn_core.sv
// router_1xn_core: byte-stream packet router steering parity-checked packets into N_CH show-ahead FIFOs
// Ports: clock, restn (async active-low); source side pkt_valid/din in, busy/error out;
// per-channel rd_en in, valid_out/dout out (channel i at dout[i*DATA_W +: DATA_W]).
// Define ROUTER_SOFT_RESET_EN to flush a channel whose head stays unread for TIMEOUT cycles.
module router_1xn_core #(
  parameter int DATA_W  = 8,
  parameter int N_CH    = 3,
  parameter int ADDR_W  = 2,
  parameter int DEPTH   = 16,
  parameter int TIMEOUT = 30
) (
  input  logic                   clock,
  input  logic                   restn,
  input  logic                   pkt_valid,
  input  logic [DATA_W-1:0]      din,
  output logic                   busy,
  output logic                   error,
  input  logic [N_CH-1:0]        rd_en,
  output logic [N_CH-1:0]        valid_out,
  output logic [N_CH*DATA_W-1:0] dout
);
  localparam int PW = $clog2(DEPTH);
  localparam int LW = DATA_W - ADDR_W;
  typedef enum logic [2:0] {IDLE, DATA, PARITY, CHECK, DROP} state_t;
  state_t state_q, state_d;
  logic [ADDR_W-1:0] dest_q, dest_d, tgt, hdr_dest;
  logic [LW-1:0] cnt_q, cnt_d, hdr_len;
  logic [DATA_W-1:0] acc_q, acc_d;
  logic error_q, error_d;
  logic [PW:0] wp_q [N_CH];
  logic [PW:0] wp_d [N_CH];
  logic [PW:0] rp_q [N_CH];
  logic [PW:0] rp_d [N_CH];
  logic [DATA_W-1:0] mem_q [N_CH][DEPTH];
  logic [N_CH-1:0] full, sel, push, pop, flush;
  logic hdr_ok, wr, accept;
  always_comb begin
    hdr_dest = din[ADDR_W-1:0];
    hdr_len = din[DATA_W-1:ADDR_W];
    tgt = (state_q == IDLE) ? hdr_dest : dest_q;
    for (int i = 0; i < N_CH; i++) begin
      full[i] = (wp_q[i][PW] != rp_q[i][PW]) && (wp_q[i][PW-1:0] == rp_q[i][PW-1:0]);
      valid_out[i] = wp_q[i] != rp_q[i];
      sel[i] = int'(tgt) == i;
      dout[i*DATA_W +: DATA_W] = valid_out[i] ? mem_q[i][rp_q[i][PW-1:0]] : '0;
    end
    hdr_ok = (int'(hdr_dest) < N_CH) && (hdr_len != '0);
    busy = (state_q == CHECK)
        || ((state_q == DATA || state_q == PARITY) && |(full & sel))
        || (state_q == IDLE && pkt_valid && int'(hdr_dest) < N_CH && |(full & sel));
    accept = pkt_valid && !busy;
    wr = accept && ((state_q == IDLE && hdr_ok) || state_q == DATA || state_q == PARITY);
    error = error_q;
  end
`ifdef ROUTER_SOFT_RESET_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] idle_q [N_CH];
  logic [TW-1:0] idle_d [N_CH];
  always_comb begin
    for (int i = 0; i < N_CH; i++) begin
      flush[i] = idle_q[i] == TW'(TIMEOUT);
      idle_d[i] = (flush[i] || !valid_out[i] || rd_en[i]) ? '0 : idle_q[i] + TW'(1);
    end
  end
  always_ff @(posedge clock or negedge restn) begin
    if (!restn) begin
      for (int i = 0; i < N_CH; i++) idle_q[i] <= '0;
    end else begin
      for (int i = 0; i < N_CH; i++) idle_q[i] <= idle_d[i];
    end
  end
`else
  always_comb flush = {N_CH{TIMEOUT < 0}};
`endif
  always_comb begin
    state_d = state_q;
    dest_d = dest_q;
    cnt_d = cnt_q;
    acc_d = acc_q;
    error_d = error_q;
    unique case (state_q)
      IDLE: if (accept) begin
        dest_d = hdr_dest;
        cnt_d = hdr_len;
        acc_d = din;
        error_d = !hdr_ok;
        state_d = hdr_ok ? DATA : DROP;
      end
      DATA: if (accept) begin
        acc_d = acc_q ^ din;
        cnt_d = cnt_q - LW'(1);
        state_d = (cnt_q == LW'(1)) ? PARITY : DATA;
      end
      PARITY: if (accept) begin
        acc_d = acc_q ^ din;
        state_d = CHECK;
      end
      CHECK: begin
        error_d = |acc_q;
        state_d = IDLE;
      end
      DROP: if (accept) begin
        cnt_d = cnt_q - LW'(1);
        state_d = (cnt_q == '0) ? IDLE : DROP;
      end
      default: state_d = IDLE;
    endcase
    if ((state_q == DATA || state_q == PARITY) && |(flush & sel)) begin
      error_d = 1'b1;
      state_d = (state_q == PARITY && accept) ? IDLE : DROP;
      cnt_d = (state_q == PARITY) ? '0 : cnt_q - LW'(accept);
    end
  end
  always_comb begin
    for (int i = 0; i < N_CH; i++) begin
      push[i] = wr && sel[i] && !flush[i];
      pop[i] = rd_en[i] && valid_out[i] && !flush[i];
      wp_d[i] = wp_q[i] + (PW+1)'(push[i]);
      rp_d[i] = flush[i] ? wp_q[i] : rp_q[i] + (PW+1)'(pop[i]);
    end
  end
  always_ff @(posedge clock or negedge restn) begin
    if (!restn) begin
      state_q <= IDLE;
      dest_q <= '0;
      cnt_q <= '0;
      acc_q <= '0;
      error_q <= 1'b0;
      for (int i = 0; i < N_CH; i++) begin
        wp_q[i] <= '0;
        rp_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      dest_q <= dest_d;
      cnt_q <= cnt_d;
      acc_q <= acc_d;
      error_q <= error_d;
      for (int i = 0; i < N_CH; i++) begin
        wp_q[i] <= wp_d[i];
        rp_q[i] <= rp_d[i];
      end
    end
  end
  always_ff @(posedge clock) begin
    for (int i = 0; i < N_CH; i++) if (push[i]) mem_q[i][wp_q[i][PW-1:0]] <= din;
  end
endmodule

// File: tb/tb_router_1xn_core.sv
// tb_router_1xn_core: randomized and directed checks of router_1xn_core against a packet-level model
module tb_router_1xn_core;
  localparam int DATA_W = 8;
  localparam int N_CH = 3;
  localparam int ADDR_W = 2;
  localparam int DEPTH = 16;
  localparam int TIMEOUT = 30;
  logic clock = 1'b0;
  logic restn = 1'b0;
  logic pkt_valid = 1'b0;
  logic [7:0] din = 8'h00;
  logic [N_CH-1:0] rd_en = '0;
  logic busy, error;
  logic [N_CH-1:0] valid_out;
  logic [N_CH*8-1:0] dout;
  int n_checks = 0;
  int n_fail = 0;
  int busy_seen = 0;
  logic last_acc = 1'b0;
  logic [7:0] tx_q [$];
  logic [7:0] mq [N_CH][$];
  int idle [N_CH];
  int rem, ch;
  logic [7:0] macc;
  logic chk, merr;
  always #5 clock = ~clock;
  router_1xn_core #(.DATA_W(DATA_W), .N_CH(N_CH), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clock(clock), .restn(restn), .pkt_valid(pkt_valid), .din(din), .busy(busy), .error(error),
    .rd_en(rd_en), .valid_out(valid_out), .dout(dout)
  );
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic model_reset();
    for (int i = 0; i < N_CH; i++) begin
      mq[i].delete();
      idle[i] = 0;
    end
    rem = 0;
    ch = -1;
    macc = 8'h00;
    chk = 1'b0;
    merr = 1'b0;
  endtask
  function automatic logic model_busy();
    int d;
    d = int'(din[1:0]);
    if (chk) return 1'b1;
    if (rem > 0) begin
      if (ch < 0) return 1'b0;
      return mq[ch].size() == DEPTH;
    end
    if (!pkt_valid || d >= N_CH) return 1'b0;
    return mq[d].size() == DEPTH;
  endfunction
  task automatic model_step(input logic b);
    logic a, abort;
    logic [N_CH-1:0] fl;
    int d, l;
    a = pkt_valid && !b;
    fl = '0;
`ifdef ROUTER_SOFT_RESET_EN
    for (int i = 0; i < N_CH; i++) fl[i] = idle[i] == TIMEOUT;
`endif
    abort = 1'b0;
    if (!chk && rem > 0 && ch >= 0) abort = fl[ch];
    for (int i = 0; i < N_CH; i++) begin
      if (fl[i]) begin
        mq[i].delete();
        idle[i] = 0;
      end else begin
        idle[i] = (mq[i].size() > 0 && !rd_en[i]) ? idle[i] + 1 : 0;
        if (rd_en[i] && mq[i].size() > 0) void'(mq[i].pop_front());
      end
    end
    last_acc = a;
    if (chk) begin
      merr = macc != 8'h00;
      chk = 1'b0;
    end else if (a) begin
      if (rem == 0) begin
        d = int'(din[1:0]);
        l = int'(din[7:2]);
        rem = l + 1;
        if (d < N_CH && l > 0) begin
          ch = d;
          macc = din;
          merr = 1'b0;
          if (!fl[d]) mq[d].push_back(din);
        end else begin
          ch = -1;
          merr = 1'b1;
        end
      end else begin
        rem--;
        if (ch >= 0) begin
          if (!fl[ch]) mq[ch].push_back(din);
          macc ^= din;
          if (rem == 0) chk = 1'b1;
        end
      end
    end
    if (abort) begin
      merr = 1'b1;
      ch = -1;
      chk = 1'b0;
    end
  endtask
  task automatic cycle();
    logic eb;
    logic [N_CH-1:0] ev;
    logic [N_CH*8-1:0] ed;
    @(negedge clock);
    eb = model_busy();
    for (int i = 0; i < N_CH; i++) begin
      ev[i] = mq[i].size() > 0;
      ed[i*8 +: 8] = ev[i] ? mq[i][0] : 8'h00;
    end
    check("busy", 32'(busy), 32'(eb));
    check("valid_out", 32'(valid_out), 32'(ev));
    check("dout", 32'(dout), 32'(ed));
    check("error", 32'(error), 32'(merr));
    if (busy === 1'b1) busy_seen++;
    model_step(eb);
    @(posedge clock);
    #1;
  endtask
  task automatic idle_cycles(input int n, input logic [N_CH-1:0] rd);
    pkt_valid = 1'b0;
    rd_en = rd;
    for (int k = 0; k < n; k++) begin
      din = 8'($urandom);
      cycle();
    end
    rd_en = '0;
  endtask
  task automatic send();
    int st;
    st = 0;
    while (tx_q.size() > 0) begin
      pkt_valid = 1'b1;
      din = tx_q[0];
      cycle();
      if (last_acc) begin
        void'(tx_q.pop_front());
        st = 0;
      end else begin
        st++;
        if (st > 40) begin
          n_checks++;
          n_fail++;
          $display("FAIL send_stall: byte %0h not accepted within 40 cycles", din);
          tx_q.delete();
        end
      end
    end
    pkt_valid = 1'b0;
  endtask
  task automatic gen_pkt();
    int r, d, l;
    logic [7:0] h, p, x;
    r = $urandom_range(0, 19);
    d = $urandom_range(0, 3);
    l = (r < 2) ? 0 : $urandom_range(1, 20);
    h = {l[5:0], d[1:0]};
    tx_q.push_back(h);
    p = h;
    for (int k = 0; k < l; k++) begin
      x = 8'($urandom);
      tx_q.push_back(x);
      p ^= x;
    end
    tx_q.push_back((r < 6) ? p ^ 8'($urandom_range(1, 255)) : p);
  endtask
  task automatic mid_reset();
    #2 restn = 1'b0;
    pkt_valid = 1'b0;
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_error", 32'(error), 32'd0);
    check("rst_valid_out", 32'(valid_out), 32'd0);
    check("rst_dout", 32'(dout), 32'd0);
    model_reset();
    tx_q.delete();
    @(posedge clock);
    #1 restn = 1'b1;
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
  initial begin
    logic [7:0] t2e [5];
    logic [7:0] p, x;
    int first_stall, pops, st, j, rdp;
    t2e = '{8'h0D, 8'h11, 8'h22, 8'h33, 8'h0D};
    model_reset();
    repeat (3) @(posedge clock);
    #1;
    check("init_busy", 32'(busy), 32'd0);
    check("init_error", 32'(error), 32'd0);
    check("init_valid_out", 32'(valid_out), 32'd0);
    check("init_dout", 32'(dout), 32'd0);
    restn = 1'b1;
    idle_cycles(2, '0);
    busy_seen = 0;
    tx_q = '{8'h0D, 8'h11, 8'h22, 8'h33, 8'h0D};
    send();
    idle_cycles(2, '0);
    check("t2_busy_cycles", 32'(busy_seen), 32'd1);
    check("t2_error", 32'(error), 32'd0);
    check("t2_valid", 32'(valid_out), 32'b010);
    rd_en = 3'b010;
    for (int k = 0; k < 5; k++) begin
      check("t2_byte", 32'(dout[15:8]), 32'(t2e[k]));
      cycle();
    end
    rd_en = '0;
    check("t2_empty", 32'(valid_out), 32'd0);
    tx_q = '{8'h0D, 8'h11, 8'h22, 8'h33, 8'h00};
    send();
    idle_cycles(2, '0);
    check("t3_error_set", 32'(error), 32'd1);
    tx_q = '{8'h05};
    send();
    check("t3_error_cleared", 32'(error), 32'd0);
    tx_q = '{8'h77, 8'h72};
    send();
    idle_cycles(2, '0);
    check("t3_good_after", 32'(error), 32'd0);
    idle_cycles(12, '1);
    tx_q.delete();
    tx_q.push_back(8'h40);
    p = 8'h40;
    for (int k = 0; k < 16; k++) begin
      x = 8'(k * 7 + 1);
      tx_q.push_back(x);
      p ^= x;
    end
    tx_q.push_back(p);
    first_stall = -1;
    pops = 0;
    st = 0;
    j = 0;
    while (tx_q.size() > 0 && st <= 20) begin
      pkt_valid = 1'b1;
      din = tx_q[0];
      rd_en = (st == 3) ? 3'b001 : 3'b000;
      if (st == 3) pops++;
      if (st == 1) check("t4_busy_held", 32'(busy), 32'd1);
      cycle();
      if (last_acc) begin
        void'(tx_q.pop_front());
        j++;
        st = 0;
      end else begin
        if (first_stall < 0) first_stall = j;
        st++;
      end
    end
    if (st > 20) begin
      n_checks++;
      n_fail++;
      $display("FAIL t4_stall: byte %0d never accepted", j);
      tx_q.delete();
    end
    rd_en = '0;
    check("t4_first_stall", 32'(first_stall), 32'd16);
    check("t4_pops", 32'(pops), 32'd2);
    idle_cycles(2, '0);
    check("t4_error", 32'(error), 32'd0);
    idle_cycles(20, '1);
    busy_seen = 0;
    tx_q = '{8'h0B, 8'h01, 8'h02, 8'h03};
    send();
    idle_cycles(2, '0);
    check("t5_error", 32'(error), 32'd1);
    check("t5_no_write", 32'(valid_out), 32'd0);
    check("t5_no_busy", 32'(busy_seen), 32'd0);
    tx_q = '{8'h05, 8'h77, 8'h72};
    send();
    idle_cycles(2, '0);
    check("t5_next_pkt_err", 32'(error), 32'd0);
    check("t5_next_pkt_ch1", 32'(valid_out), 32'b010);
    idle_cycles(6, '1);
`ifdef ROUTER_SOFT_RESET_EN
    tx_q = '{8'h06};
    send();
    tx_q = '{8'hAA, 8'hAC};
    j = 0;
    while (valid_out[2] && j < 60) begin
      pkt_valid = tx_q.size() > 0;
      din = pkt_valid ? tx_q[0] : 8'h00;
      cycle();
      if (last_acc) void'(tx_q.pop_front());
      j++;
    end
    pkt_valid = 1'b0;
    check("t6_flush_cycle", 32'(j), 32'd31);
    check("t6_others", 32'(valid_out), 32'd0);
    tx_q.delete();
`endif
    for (int c = 0; c < 2400; c++) begin
      rdp = (c < 600) ? 60 : (c < 1200) ? 5 : (c < 1800) ? 50 : 85;
      if (c == 1300) mid_reset();
      if (tx_q.size() == 0) gen_pkt();
      pkt_valid = $urandom_range(0, 9) < 8;
      din = pkt_valid ? tx_q[0] : 8'($urandom);
      for (int i = 0; i < N_CH; i++) rd_en[i] = $urandom_range(0, 99) < rdp;
      cycle();
      if (last_acc) void'(tx_q.pop_front());
    end
    idle_cycles(4, '1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
